// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// exception cause codes and the default sequential PC increment.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_EXT      = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

    localparam int unsigned INSTR_BYTES_DEF = 4;

endpackage

// File: rtl/fetch_timer.sv
// Counts no-ack cycles while waiting on instruction memory; expired flags
// the last permitted cycle (count == TIMEOUT-1).
module fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/update controller driving the PC register write port.
// Define PCSEQ_PERF_CNT_EN to add retired_cnt / fetch_wait_cnt outputs.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 64,
    parameter int unsigned        INSTR_BYTES = INSTR_BYTES_DEF,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = ADDR_W'(64'h0),
    parameter logic [ADDR_W-1:0]  EXC_VEC     = ADDR_W'(64'h100),
    parameter int unsigned        TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_cur,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_we,
    input  logic              stall,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              ir_we,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_in,
    input  logic              halt_in,
    output logic [1:0]        exc_cause,
    output logic [ADDR_W-1:0] epc,
    output logic              halted,
    output logic [2:0]        state_o
`ifdef PCSEQ_PERF_CNT_EN
    ,
    output logic [63:0]       retired_cnt,
    output logic [63:0]       fetch_wait_cnt
`endif
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] next_r, next_n;
    logic [1:0]        cause_n;
    logic [ADDR_W-1:0] epc_n;
    logic              timer_clr, timer_en, timer_exp;

    fetch_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_exp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LOAD;
            next_r    <= '0;
            exc_cause <= CAUSE_NONE;
            epc       <= '0;
        end else begin
            state     <= state_n;
            next_r    <= next_n;
            exc_cause <= cause_n;
            epc       <= epc_n;
        end
    end

    // Next-state and exception capture; EXEC priority: exc > halt > misaligned > normal.
    always_comb begin
        state_n   = state;
        next_n    = next_r;
        cause_n   = exc_cause;
        epc_n     = epc;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state)
            S_LOAD:   state_n = S_FETCH;
            S_FETCH: begin
                if (!stall) begin
                    state_n   = S_WAIT;
                    timer_clr = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_n = S_EXEC;
                end else if (timer_exp) begin
                    cause_n = CAUSE_TIMEOUT;
                    epc_n   = pc_cur;
                    next_n  = EXC_VEC;
                    state_n = S_UPDATE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            S_EXEC: begin
                if (br_valid) begin
                    state_n = S_UPDATE;
                    if (exc_in) begin
                        cause_n = CAUSE_EXT;
                        epc_n   = pc_cur;
                        next_n  = EXC_VEC;
                    end else if (halt_in) begin
                        state_n = S_HALT;
                    end else if (br_taken && (br_target[1:0] != 2'b00)) begin
                        cause_n = CAUSE_MISALIGN;
                        epc_n   = pc_cur;
                        next_n  = EXC_VEC;
                    end else if (br_taken) begin
                        next_n  = br_target;
                    end else begin
                        next_n  = pc_cur + ADDR_W'(INSTR_BYTES);
                    end
                end
            end
            S_UPDATE: state_n = S_FETCH;
            S_HALT:   state_n = S_HALT;
            default:  state_n = S_LOAD;
        endcase
    end

    // State-decoded outputs, forced quiet while reset is high.
    always_comb begin
        pc_we    = 1'b0;
        pc_next  = '0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        if (!reset) begin
            case (state)
                S_LOAD: begin
                    pc_we   = 1'b1;
                    pc_next = RESET_VEC;
                end
                S_UPDATE: begin
                    pc_we   = 1'b1;
                    pc_next = next_r;
                end
                S_WAIT: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                default: ;
            endcase
        end
    end

    assign halted  = (state == S_HALT);
    assign state_o = state;

`ifdef PCSEQ_PERF_CNT_EN
    logic exc_upd;

    // Marks an UPDATE that is writing an exception vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_upd        <= 1'b0;
            retired_cnt    <= '0;
            fetch_wait_cnt <= '0;
        end else begin
            exc_upd <= (cause_n != exc_cause) || (epc_n != epc) ||
                       ((state == S_WAIT) && !imem_ack && timer_exp) ||
                       ((state == S_EXEC) && br_valid &&
                        (exc_in || (!halt_in && br_taken && (br_target[1:0] != 2'b00))));
            if ((state == S_UPDATE) && !exc_upd) begin
                retired_cnt <= retired_cnt + 64'd1;
            end
            if ((state == S_WAIT) && !imem_ack) begin
                fetch_wait_cnt <= fetch_wait_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected PC writes,
// a forked monitor pops and compares on every pc_we.
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic [63:0] pc_cur;
    logic [63:0] pc_next;
    logic        pc_we;
    logic        stall;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        br_valid;
    logic        br_taken;
    logic [63:0] br_target;
    logic        exc_in;
    logic        halt_in;
    logic [1:0]  exc_cause;
    logic [63:0] epc;
    logic        halted;
    logic [2:0]  state_o;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .pc_cur    (pc_cur),
        .pc_next   (pc_next),
        .pc_we     (pc_we),
        .stall     (stall),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .ir_we     (ir_we),
        .br_valid  (br_valid),
        .br_taken  (br_taken),
        .br_target (br_target),
        .exc_in    (exc_in),
        .halt_in   (halt_in),
        .exc_cause (exc_cause),
        .epc       (epc),
        .halted    (halted),
        .state_o   (state_o)
    );

    typedef struct {
        logic [63:0] pc;
        logic [1:0]  cause;
        logic [63:0] epc;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   irwe_seen;
    int   irwe_exp;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [63:0] pc, input logic [1:0] cause, input logic [63:0] e);
        exp_t x;
        x.pc = pc;
        x.cause = cause;
        x.epc = e;
        q.push_back(x);
    endtask

    // Starts in FETCH; acks on the ack_at-th WAIT cycle; ends in EXEC.
    task automatic do_fetch(input int ack_at);
        stall = 1'b0;
        step();
        stall = 1'b1;
        for (int i = 1; i < ack_at; i++) begin
            imem_ack = 1'b0;
            step();
        end
        imem_ack = 1'b1;
        irwe_exp++;
        step();
        imem_ack = 1'b0;
    endtask

    // Starts in EXEC; presents one execute result; ends in FETCH unless halting.
    task automatic do_exec(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                           input logic ex, input logic hl);
        pc_cur    = pc;
        br_valid  = 1'b1;
        br_taken  = tk;
        br_target = tgt;
        exc_in    = ex;
        halt_in   = hl;
        step();
        br_valid = 1'b0;
        br_taken = 1'b0;
        exc_in   = 1'b0;
        halt_in  = 1'b0;
        if (!(hl && !ex)) step();
    endtask

    task automatic monitor();
        exp_t x;
        forever begin
            @(negedge clk);
            if (ir_we) irwe_seen++;
            if (pc_we) begin
                if (q.size() == 0) begin
                    check("unexpected_pc_we", {63'd0, pc_we}, 64'd0);
                end else begin
                    x = q.pop_front();
                    check("pc_next", pc_next, x.pc);
                    check("exc_cause", {62'd0, exc_cause}, {62'd0, x.cause});
                    check("epc", epc, x.epc);
                end
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0; irwe_seen = 0; irwe_exp = 0;
        reset = 1'b1; stall = 1'b1; pc_cur = '0; imem_ack = 1'b0;
        br_valid = 1'b0; br_taken = 1'b0; br_target = '0; exc_in = 1'b0; halt_in = 1'b0;
        fork
            monitor();
        join_none

        // Reset, LOAD write, then a plain sequential instruction
        repeat (3) step();
        check("rst_pc_we", {63'd0, pc_we}, 64'd0);
        check("rst_imem_req", {63'd0, imem_req}, 64'd0);
        check("rst_state", {61'd0, state_o}, 64'd0);
        check("rst_halted", {63'd0, halted}, 64'd0);
        expect_wr(64'h0, 2'd0, 64'h0);
        reset = 1'b0;
        step();
        do_fetch(2);
        expect_wr(64'h4, 2'd0, 64'h0);
        do_exec(64'h0, 1'b0, 64'h0, 1'b0, 1'b0);

        // Taken aligned branch, then taken misaligned branch
        do_fetch(1);
        expect_wr(64'h80, 2'd0, 64'h0);
        do_exec(64'h40, 1'b1, 64'h80, 1'b0, 1'b0);
        do_fetch(1);
        expect_wr(64'h100, 2'd2, 64'h40);
        do_exec(64'h40, 1'b1, 64'h82, 1'b0, 1'b0);

        // Fetch timeout after 16 WAIT cycles
        pc_cur = 64'h8;
        expect_wr(64'h100, 2'd3, 64'h8);
        stall = 1'b0;
        step();
        stall = 1'b1;
        repeat (16) begin
            check("wait_imem_req", {63'd0, imem_req}, 64'd1);
            step();
        end
        check("timeout_state", {61'd0, state_o}, 64'd4);
        step();

        // Ack in the 16th WAIT cycle wins; cause/epc held from previous exception
        do_fetch(16);
        check("late_ack_state", {61'd0, state_o}, 64'd3);
        expect_wr(64'hC, 2'd3, 64'h8);
        do_exec(64'h8, 1'b0, 64'h0, 1'b0, 1'b0);

        // exc_in outranks halt_in
        do_fetch(1);
        expect_wr(64'h100, 2'd1, 64'h20);
        do_exec(64'h20, 1'b1, 64'h80, 1'b1, 1'b1);

        // Stall for 5 cycles with a stray ack, then PC wrap
        imem_ack = 1'b1;
        repeat (5) begin
            #1;
            check("stall_imem_req", {63'd0, imem_req}, 64'd0);
            check("stall_state", {61'd0, state_o}, 64'd1);
            step();
        end
        imem_ack = 1'b0;
        do_fetch(1);
        expect_wr(64'h0, 2'd1, 64'h20);
        do_exec(64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 1'b0);

        // Reset mid-WAIT
        stall = 1'b0;
        step();
        step();
        check("mid_wait_req", {63'd0, imem_req}, 64'd1);
        reset = 1'b1;
        #1;
        check("reset_gates_req", {63'd0, imem_req}, 64'd0);
        step();
        check("reset_state", {61'd0, state_o}, 64'd0);
        check("reset_pc_we", {63'd0, pc_we}, 64'd0);
        check("reset_imem_req", {63'd0, imem_req}, 64'd0);
        stall = 1'b1;
        expect_wr(64'h0, 2'd0, 64'h0);
        reset = 1'b0;
        step();

        // Halt alone: no PC write, acks ignored
        do_fetch(1);
        do_exec(64'h30, 1'b0, 64'h0, 1'b0, 1'b1);
        imem_ack = 1'b1;
        br_valid = 1'b1;
        repeat (4) begin
            #1;
            check("halt_halted", {63'd0, halted}, 64'd1);
            check("halt_state", {61'd0, state_o}, 64'd5);
            check("halt_imem_req", {63'd0, imem_req}, 64'd0);
            step();
        end
        imem_ack = 1'b0;
        br_valid = 1'b0;
        step();

        check("ir_we_count", 64'(irwe_seen), 64'(irwe_exp));
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
